// File: rtl/spi_master_tx.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transmitter.
// Accepts words on a valid/ready handshake and shifts them out MSB-first.
// SCLK is derived from the system clock: each SCLK half-period lasts CLK_DIV clocks.
// Back-to-back words are chained without releasing SS when the next word is
// offered in the one-cycle burst window at the end of the last bit's high phase.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   io_txData/Valid     word to send and its valid strobe
//   io_txReady          high in IDLE and in the burst window
//   io_SPISignals_*     registered SCLK / MOSI / SS (SS active low)
//   io_busy             high whenever the FSM is not IDLE
//   io_done             one-cycle pulse at the last falling SCLK edge of a word
module spi_master_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] io_txData,
  input  logic                  io_txValid,
  output logic                  io_txReady,
  output logic                  io_SPISignals_SCLK,
  output logic                  io_SPISignals_MOSI,
  output logic                  io_SPISignals_SS,
  output logic                  io_busy,
  output logic                  io_done
);

  localparam int unsigned BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [7:0]    HLAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER_HI, XFER_LO, TAIL, GAP} state_t;

  state_t                state, state_n;
  logic [7:0]            hcnt, hcnt_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic [WORD_WIDTH-1:0] shreg, shreg_n;
  logic                  pend, pend_n;
  logic                  sclk_q, sclk_n;
  logic                  ss_q, ss_n;
  logic                  mosi_q, mosi_n;
  logic                  done_q, done_n;

  logic half_last, bit_last, burst_win, accept;

  assign half_last = (hcnt == HLAST);
  assign bit_last  = (bcnt == BLAST);
  assign burst_win = (state == XFER_HI) && half_last && bit_last;
  assign accept    = io_txValid && io_txReady;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      hcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      pend   <= 1'b0;
      sclk_q <= 1'b0;
      ss_q   <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      hcnt   <= hcnt_n;
      bcnt   <= bcnt_n;
      shreg  <= shreg_n;
      pend   <= pend_n;
      sclk_q <= sclk_n;
      ss_q   <= ss_n;
      mosi_q <= mosi_n;
      done_q <= done_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = LEAD;
      LEAD:    if (half_last) state_n = XFER_HI;
      XFER_HI: if (half_last) state_n = XFER_LO;
      // The last bit still gets a full low phase; a chained word then
      // continues straight into its first high phase.
      XFER_LO: if (half_last) state_n = (!bit_last || pend) ? XFER_HI : TAIL;
      TAIL:    if (half_last) state_n = GAP;
      GAP:     if (half_last) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Outputs and next values of the registered pins/datapath
  always_comb begin
    io_txReady = !reset && ((state == IDLE) || burst_win);
    io_busy    = (state != IDLE);

    hcnt_n  = (state_n != state || state == IDLE) ? '0 : hcnt + 8'd1;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    mosi_n  = mosi_q;
    pend_n  = pend;

    if (state == XFER_LO && half_last)
      bcnt_n = bit_last ? '0 : bcnt + BW'(1);

    if (accept) begin
      // IDLE start or burst chain: new MSB goes out on this edge.
      shreg_n = io_txData;
      mosi_n  = io_txData[WORD_WIDTH-1];
    end else if (state == XFER_HI && half_last && !bit_last) begin
      shreg_n = {shreg[WORD_WIDTH-2:0], 1'b0};
      mosi_n  = shreg[WORD_WIDTH-2];
    end else if (state == TAIL && half_last) begin
      shreg_n = '0;
      mosi_n  = 1'b0;
    end

    if (accept && state == XFER_HI)
      pend_n = 1'b1;
    else if (state == XFER_LO && half_last && bit_last)
      pend_n = 1'b0;

    // Pins are registered copies of the decoded next state.
    sclk_n = (state_n == XFER_HI);
    ss_n   = !(state_n == LEAD || state_n == XFER_HI ||
               state_n == XFER_LO || state_n == TAIL);
    done_n = burst_win;
  end

  assign io_SPISignals_SCLK = sclk_q;
  assign io_SPISignals_MOSI = mosi_q;
  assign io_SPISignals_SS   = ss_q;
  assign io_done            = done_q;

endmodule
